// File: rtl/wolfram_ca_pkg.sv
// wolfram_ca_pkg: shared types and helpers for the elementary cellular automaton.
//   ca_state_t  : controller FSM states (IDLE, RUN)
//   RULE_W      : width of the Wolfram rule byte
//   rule_lookup : output bit of a rule for neighbourhood {l,c,r}. The rule MSB
//                 covers neighbourhood 000, so hex rule names match the
//                 fixed truth-table modules (0x79 == m0x79).
package wolfram_ca_pkg;

  localparam int RULE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ca_state_t;

  function automatic logic rule_lookup(input logic [RULE_W-1:0] rule,
                                       input logic l, input logic c, input logic r);
    logic [2:0] idx;
    idx = {l, c, r};
    return rule[3'd7 - idx];
  endfunction

endpackage

// File: rtl/wolfram_ca_next_state.sv
// ca_next_state: purely combinational one-generation step of the automaton.
//   state_i    : current cell vector
//   rule_i     : rule byte
//   boundary_i : 0 = wrap-around edges, 1 = fixed-zero edges
//   next_o     : next cell vector
// Cell i sees L = c[i+1], C = c[i], R = c[i-1].
module ca_next_state
  import wolfram_ca_pkg::*;
#(
  parameter int CELLS = 16
) (
  input  logic [CELLS-1:0]  state_i,
  input  logic [RULE_W-1:0] rule_i,
  input  logic              boundary_i,
  output logic [CELLS-1:0]  next_o
);

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    logic l, r;

    // Only the two end cells need an edge mux; interior cells are plain wiring.
    if (i == CELLS-1) begin : g_l_edge
      assign l = boundary_i ? 1'b0 : state_i[0];
    end else begin : g_l_mid
      assign l = state_i[i+1];
    end

    if (i == 0) begin : g_r_edge
      assign r = boundary_i ? 1'b0 : state_i[CELLS-1];
    end else begin : g_r_mid
      assign r = state_i[i-1];
    end

    assign next_o[i] = rule_lookup(rule_i, l, state_i[i], r);
  end

endmodule

// File: rtl/wolfram_ca.sv
// wolfram_ca: runtime-programmable 1-D elementary cellular automaton.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   rule_i       : rule byte, latched on accepted start
//   boundary_i   : 0 wrap / 1 zero edges, latched on accepted start
//   seed_i       : initial state, loaded on accepted load
//   load_i       : load seed (IDLE only; wins over start)
//   start_i      : begin a run of steps_i generations (IDLE only)
//   steps_i      : generation count, latched on accepted start
//   abort_i      : end a run early, holding state and gen (RUN only)
//   busy_o       : high while in RUN
//   done_o       : one-cycle pulse on normal completion
//   stable_o     : sticky, a generation reproduced its predecessor
//   state_o      : current cell register
//   gen_o        : generations applied since last load/start
module wolfram_ca
  import wolfram_ca_pkg::*;
#(
  parameter int CELLS  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RULE_W-1:0] rule_i,
  input  logic              boundary_i,
  input  logic [CELLS-1:0]  seed_i,
  input  logic              load_i,
  input  logic              start_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              stable_o,
  output logic [CELLS-1:0]  state_o,
  output logic [STEP_W-1:0] gen_o
);

  ca_state_t         fsm_q, fsm_d;
  logic [CELLS-1:0]  state_q, state_d, next_state;
  logic [STEP_W-1:0] gen_q, gen_d, steps_q, steps_d;
  logic [RULE_W-1:0] rule_q, rule_d;
  logic              bnd_q, bnd_d;
  logic              stable_q, stable_d;
  logic              done_q, done_d;
  logic              last_gen;

  ca_next_state #(.CELLS(CELLS)) u_next (
    .state_i    (state_q),
    .rule_i     (rule_q),
    .boundary_i (bnd_q),
    .next_o     (next_state)
  );

  // True on the RUN cycle whose update brings gen up to the requested count.
  assign last_gen = (gen_q + STEP_W'(1)) == steps_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (!load_i && start_i && steps_i != '0) fsm_d = RUN;
      RUN:  if (abort_i || last_gen)                 fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (fsm_q == RUN);
  end

  // Datapath next values
  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    steps_d  = steps_q;
    rule_d   = rule_q;
    bnd_d    = bnd_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (load_i) begin
          state_d  = seed_i;
          gen_d    = '0;
          stable_d = 1'b0;
        end else if (start_i) begin
          rule_d   = rule_i;
          bnd_d    = boundary_i;
          steps_d  = steps_i;
          gen_d    = '0;
          stable_d = 1'b0;
          done_d   = (steps_i == '0);
        end
      end
      RUN: begin
        // Abort freezes everything; the update only happens without it.
        if (!abort_i) begin
          state_d  = next_state;
          gen_d    = gen_q + STEP_W'(1);
          stable_d = stable_q | (next_state == state_q);
          done_d   = last_gen;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      gen_q    <= '0;
      steps_q  <= '0;
      rule_q   <= '0;
      bnd_q    <= 1'b0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      steps_q  <= steps_d;
      rule_q   <= rule_d;
      bnd_q    <= bnd_d;
      stable_q <= stable_d;
      done_q   <= done_d;
    end
  end

  assign done_o   = done_q;
  assign stable_o = stable_q;
  assign state_o  = state_q;
  assign gen_o    = gen_q;

endmodule

// File: tb/tb_wolfram_ca.sv
module tb_wolfram_ca;
  localparam int CELLS  = 8;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rule_i = '0;
  logic              boundary_i = 1'b0;
  logic [CELLS-1:0]  seed_i = '0;
  logic              load_i = 1'b0;
  logic              start_i = 1'b0;
  logic [STEP_W-1:0] steps_i = '0;
  logic              abort_i = 1'b0;
  logic              busy_o, done_o, stable_o;
  logic [CELLS-1:0]  state_o;
  logic [STEP_W-1:0] gen_o;

  int vectors = 0;
  int miscompares = 0;

  wolfram_ca #(.CELLS(CELLS), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .rule_i(rule_i), .boundary_i(boundary_i),
    .seed_i(seed_i), .load_i(load_i), .start_i(start_i), .steps_i(steps_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .stable_o(stable_o),
    .state_o(state_o), .gen_o(gen_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // One generation computed straight from the rule definition: look up the
  // neighbourhood number n = 4L+2C+R and take bit (7-n) of the rule.
  function automatic logic [CELLS-1:0] model_next(input logic [CELLS-1:0] s,
                                                  input logic [7:0] rule, input bit zero_edges);
    logic [CELLS-1:0] o;
    int l, c, r, n;
    o = '0;
    for (int i = 0; i < CELLS; i++) begin
      c = int'(s[i]);
      if (i == CELLS-1) l = zero_edges ? 0 : int'(s[0]); else l = int'(s[i+1]);
      if (i == 0) r = zero_edges ? 0 : int'(s[CELLS-1]); else r = int'(s[i-1]);
      n = 4*l + 2*c + r;
      o[i] = rule[7-n];
    end
    return o;
  endfunction

  logic [CELLS-1:0] m_state;
  logic [7:0]       m_rule;
  bit               m_zero, m_busy, m_done, m_stable;
  int               m_gen, m_steps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= '0; m_rule <= '0; m_zero <= 0; m_busy <= 0;
      m_done <= 0; m_stable <= 0; m_gen <= 0; m_steps <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (load_i) begin
          m_state <= seed_i; m_gen <= 0; m_stable <= 0;
        end else if (start_i) begin
          m_rule <= rule_i; m_zero <= boundary_i; m_steps <= int'(steps_i);
          m_gen <= 0; m_stable <= 0;
          if (steps_i == 0) m_done <= 1; else m_busy <= 1;
        end
      end else if (abort_i) begin
        m_busy <= 0;
      end else begin
        m_state <= model_next(m_state, m_rule, m_zero);
        m_gen   <= m_gen + 1;
        if (model_next(m_state, m_rule, m_zero) == m_state) m_stable <= 1;
        if (m_gen + 1 == m_steps) begin m_busy <= 0; m_done <= 1; end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model.state",  32'(state_o),  32'(m_state));
    chk("model.gen",    32'(gen_o),    32'(m_gen));
    chk("model.busy",   32'(busy_o),   32'(m_busy));
    chk("model.done",   32'(done_o),   32'(m_done));
    chk("model.stable", 32'(stable_o), 32'(m_stable));
  endtask

  // Advance one cycle: wait for the falling edge, let outputs settle, compare
  // against the model; inputs are then driven well away from the rising edge.
  task automatic step();
    @(negedge clk); #1;
    compare_model();
  endtask

  task automatic do_load(input logic [CELLS-1:0] seed);
    seed_i = seed; load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  // Drives start for one edge; returns just after edge k (busy should be up).
  task automatic do_start(input logic [7:0] rule, input bit zero, input int steps);
    rule_i = rule; boundary_i = zero; steps_i = STEP_W'(steps); start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #1; compare_model();
    step();
    chk("reset.state", 32'(state_o), 32'h0);
    chk("reset.busy",  32'(busy_o),  32'h0);
    rst_n = 1'b1;
    step();

    // Single seed: 0x10 under rule 0x79 wrap -> 0x38 after one generation.
    do_load(8'h10);
    do_start(8'h79, 1'b0, 1);
    chk("seed.busy", 32'(busy_o), 32'h1);
    step();
    chk("seed.state", 32'(state_o), 32'h38);
    chk("seed.gen",   32'(gen_o),   32'h1);
    chk("seed.done",  32'(done_o),  32'h1);
    step();
    chk("seed.done_once", 32'(done_o), 32'h0);

    // Boundary modes on seed 0x01.
    do_load(8'h01);
    do_start(8'h79, 1'b0, 1);
    step();
    chk("wrap.state", 32'(state_o), 32'h83);
    do_load(8'h01);
    do_start(8'h79, 1'b1, 1);
    step();
    chk("zero.state", 32'(state_o), 32'h03);

    // Fixed point: rule 0 empties the row, then repeats.
    do_load(8'hFF);
    do_start(8'h00, 1'b0, 3);
    step();
    chk("fix.state1",  32'(state_o),  32'h00);
    chk("fix.stable1", 32'(stable_o), 32'h0);
    step();
    chk("fix.stable2", 32'(stable_o), 32'h1);
    step();
    chk("fix.gen3",  32'(gen_o),  32'h3);
    chk("fix.done3", 32'(done_o), 32'h1);

    // Abort on the 3rd RUN cycle; two generations of 0x10 under 0x79 is 0x74.
    do_load(8'h10);
    do_start(8'h79, 1'b0, 10);
    step();
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort.gen",   32'(gen_o),   32'h2);
    chk("abort.state", 32'(state_o), 32'h74);
    chk("abort.busy",  32'(busy_o),  32'h0);
    chk("abort.done",  32'(done_o),  32'h0);
    step();

    // Zero-step start: immediate done, state untouched.
    do_load(8'h5A);
    do_start(8'h96, 1'b0, 0);
    chk("zstep.done",  32'(done_o),  32'h1);
    chk("zstep.busy",  32'(busy_o),  32'h0);
    chk("zstep.state", 32'(state_o), 32'h5A);
    step();

    // Load and start together: load wins.
    seed_i = 8'hC3; load_i = 1'b1; start_i = 1'b1; steps_i = 8'd5;
    step();
    load_i = 1'b0; start_i = 1'b0;
    chk("ldst.state", 32'(state_o), 32'hC3);
    chk("ldst.busy",  32'(busy_o),  32'h0);
    step();

    // Abort while idle is ignored; longer runs with inputs disturbed mid-run.
    abort_i = 1'b1; step(); abort_i = 1'b0;
    do_load(8'h01);
    do_start(8'h6E, 1'b1, 20);
    for (int i = 0; i < 22; i++) begin
      rule_i = 8'($urandom); steps_i = 8'($urandom); boundary_i = 1'($urandom);
      load_i = (i == 4); start_i = (i == 6); seed_i = 8'hAA;
      step();
    end
    load_i = 1'b0; start_i = 1'b0;
    do_load(8'h81);
    do_start(8'h96, 1'b0, 12);
    for (int i = 0; i < 14; i++) step();
    do_load(8'h00);
    do_start(8'hFE, 1'b0, 4);
    for (int i = 0; i < 6; i++) step();

    // Async reset mid-run, then accept a new load.
    do_load(8'h10);
    do_start(8'h79, 1'b0, 200);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1; compare_model();
    chk("rst.state",  32'(state_o),  32'h0);
    chk("rst.gen",    32'(gen_o),    32'h0);
    chk("rst.busy",   32'(busy_o),   32'h0);
    chk("rst.stable", 32'(stable_o), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    do_load(8'h0F);
    chk("rst.reload", 32'(state_o), 32'h0F);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wolfram_ca.md
# wolfram_ca

Parametrised one-dimensional elementary cellular automaton. The block generalises the fixed 3-input truth-table modules (such as `m0x79`) in three ways: it takes a runtime-programmable 8-bit rule, holds a `CELLS`-wide register of state, and iterates the rule for a requested number of generations. It is a sequential reference model and stimulus source for 3-input logic circuits; a controller loads a seed, starts a run, and reads back the final state.

## Interface
- `CELLS`, 16: number of cells; must be ≥ 3.
- `STEP_W`, 8: width of the step count and the generation counter.

- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rule_i`  in  8  rule byte; latched on accepted start.
- `boundary_i`  in  1  0 = wrap-around, 1 = fixed-zero edges; latched on accepted start.
- `seed_i`  in  CELLS  initial state; loaded on accepted load.
- `load_i`  in  1  load `seed_i`; accepted only in IDLE.
- `start_i`  in  1  begin a run; accepted only in IDLE.
- `steps_i`  in  STEP_W  number of generations to compute; latched on accepted start.
- `abort_i`  in  1  terminate a run early.
- `busy_o`  out  1  high while in RUN.
- `done_o`  out  1  one-cycle pulse when a run completes normally.
- `stable_o`  out  1  sticky flag: a fixed point was reached during the run.
- `state_o`  out  CELLS  current cell register.
- `gen_o`  out  STEP_W  generations applied since the last load or start.

## Operation
- **Neighbourhood of cell i:** L = c[i+1], C = c[i], R = c[i-1].
  - Wrap mode: c[CELLS] is c[0] and c[-1] is c[CELLS-1].
  - Zero mode: out-of-range neighbours are 0.
- **Next-state rule:** next c[i] = rule[7 − {L,C,R}]. The rule MSB is the output for neighbourhood 000. This matches the team's hex naming, so rule 0x79 reproduces `m0x79`.
- **FSM states:** IDLE and RUN.
  - IDLE + load_i: state ← seed_i, gen ← 0, stable ← 0.
  - IDLE + start_i with steps_i = 0: latch rule and boundary, gen ← 0, stable ← 0, pulse done_o, stay in IDLE.
  - IDLE + start_i with steps_i > 0: latch rule, boundary and steps; gen ← 0; stable ← 0; go to RUN.
  - load_i and start_i in the same IDLE cycle: load wins and start is ignored.
  - RUN: each cycle, state ← next(state) and gen ← gen + 1. If next == state, stable ← 1; the run continues regardless.
  - RUN, the cycle gen reaches steps: go to IDLE and pulse done_o.
  - RUN + abort_i: go to IDLE on that edge with no update and no done_o; state and gen are held. abort_i has priority over the update.
- **Ignored inputs:** load_i and start_i are ignored in RUN. abort_i is ignored in IDLE. Changes to rule_i, boundary_i and steps_i during RUN have no effect.
- **Reset:** async reset, including mid-run, forces IDLE with state, gen, busy, done and stable all 0.

## Timing
- **Reset values:** all outputs 0.
- **Start sampled at edge k with steps = N > 0:**
  - busy_o = 1 after edge k.
  - Generations are applied on edges k+1 … k+N.
  - After edge k+N: busy_o = 0, done_o = 1 for one cycle, gen_o = N.
  - Latency from start to done is N+1 edges.
- **Start with steps = 0:** done_o = 1 after edge k; busy_o stays 0; state is unchanged.
- **Next-state logic:** purely combinational from registered state; one generation per cycle at full throughput.
- **stable_o:** updates on the same edge as the generation that produced a repeat.
- **gen_o:** cannot wrap within a run, because gen ≤ steps ≤ 2^STEP_W − 1.

## Structure
- **`wolfram_ca_pkg`:**
  - state enum `ca_state_t` {IDLE, RUN}
  - `RULE_W` = 8
  - function `rule_lookup(rule, l, c, r)`, implementing rule[7 − {l,c,r}]
- **Sub-module `ca_next_state`:** combinational; parameter `CELLS`; inputs state, rule, boundary; output next. The top level holds only the FSM, counters and registers.

## Test plan
- **Reset:** assert rst_n low mid-run (steps = 200, cycle 5) → next cycle all outputs are 0 and the block accepts a new load.
- **Single seed:** CELLS = 8, rule 0x79, wrap, seed 0x10, steps 1 → after 2 edges state_o = 0x38, gen_o = 1, done_o pulses once.
- **Boundary modes:** CELLS = 8, rule 0x79, seed 0x01, steps 1 → wrap gives 0x83; zero gives 0x03.
- **Fixed point:** rule 0x00, seed 0xFF, steps 3 → state 0x00 after generation 1; stable_o = 1 after generation 2; done at gen_o = 3.
- **Abort:** rule 0x79, seed 0x10, steps 10, abort_i at the 3rd RUN cycle → gen_o = 2, state_o = two-step value, no done_o, busy_o = 0.
- **Edge commands:**
  - steps 0 → done_o one cycle after start, busy_o never high, state unchanged.
  - load and start in the same cycle → seed loaded, busy_o stays 0.
